clk_period_meter: RTL and testbench

Measures a slow, asynchronous clock-like signal, such as the divided clock produced by the team's clock divider, in units of the fast system clock. It synchronizes the input, detects edges, and reports the period and high time for each cycle. It flags lock after a run of identical periods and flags timeout when the signal stalls. It sits at the consuming end of a divided-clock path and is used as an on-chip check of divider ratio and duty cycle.

---
 rtl/clk_period_meter.sv | 160 ++++++++++++++++
 tb/tb_clk_period_meter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, asynchronous signal in
// clk_in cycles, flags lock after a run of equal periods and flags a sticky stall timeout.
module clk_period_meter #(
   parameter int unsigned max_period = 1024,
   parameter int unsigned lock_count = 4,
   localparam int unsigned W = $clog2(max_period + 1)
) (
   input  logic         clk_in,
   input  logic         reset,
   input  logic         sig_in,
   input  logic         enable,
   output logic [W-1:0] period_out,
   output logic [W-1:0] high_out,
   output logic         meas_valid,
   output logic         locked,
   output logic         timeout
);

   localparam int unsigned   MW       = $clog2(lock_count);
   localparam logic [W-1:0]  MaxCnt   = W'(max_period);
   localparam logic [W-1:0]  OneCnt   = W'(1);
   localparam logic [MW-1:0] MatchMax = MW'(lock_count - 1);

   typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_t;

   state_t        r_state, w_state_d;
   logic          r_s1, r_s2, r_s3;
   logic          w_rise, w_fall;
   logic [W-1:0]  r_cnt, w_cnt_d;
   logic [W-1:0]  r_high_cap, w_high_cap_d;
   logic [W-1:0]  r_period, w_period_d;
   logic [W-1:0]  r_high, w_high_d;
   logic [MW-1:0] r_match, w_match_d;
   logic          r_valid, w_valid_d;
   logic          r_locked, w_locked_d;
   logic          r_timeout, w_timeout_d;
   logic          r_first, w_first_d;

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;

   // Two-flop synchronizer plus history flop for edge detection.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_high_cap <= '0;
         r_period   <= '0;
         r_high     <= '0;
         r_match    <= '0;
         r_valid    <= 1'b0;
         r_locked   <= 1'b0;
         r_timeout  <= 1'b0;
         r_first    <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_high_cap <= w_high_cap_d;
         r_period   <= w_period_d;
         r_high     <= w_high_d;
         r_match    <= w_match_d;
         r_valid    <= w_valid_d;
         r_locked   <= w_locked_d;
         r_timeout  <= w_timeout_d;
         r_first    <= w_first_d;
      end
   end

   // Next-state logic: arming, measurement capture, lock tracking and stall timeout.
   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_high_cap_d = r_high_cap;
      w_period_d   = r_period;
      w_high_d     = r_high;
      w_match_d    = r_match;
      w_valid_d    = 1'b0;
      w_locked_d   = r_locked;
      w_timeout_d  = r_timeout;
      w_first_d    = r_first;

      if (!enable) begin
         // Disabling discards any measurement in progress; reported values are held.
         w_state_d   = StIdle;
         w_cnt_d     = '0;
         w_match_d   = '0;
         w_locked_d  = 1'b0;
         w_timeout_d = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_state_d   = StArm;
               w_cnt_d     = '0;
               w_match_d   = '0;
               w_locked_d  = 1'b0;
               w_timeout_d = 1'b0;
            end
            StArm: begin
               // First edge has no predecessor, so it only starts the count.
               if (w_rise) begin
                  w_cnt_d   = OneCnt;
                  w_first_d = 1'b1;
                  w_state_d = StMeasure;
               end
            end
            StMeasure: begin
               if (w_rise) begin
                  // A rise on the saturation cycle is still a valid max_period measurement.
                  w_period_d  = r_cnt;
                  w_high_d    = r_high_cap;
                  w_valid_d   = 1'b1;
                  w_timeout_d = 1'b0;
                  w_cnt_d     = OneCnt;
                  w_first_d   = 1'b0;
                  if (r_first) begin
                     w_match_d = '0;
                  end else if (r_cnt == r_period) begin
                     if (r_match != MatchMax) w_match_d = r_match + 1'b1;
                     if (w_match_d == MatchMax) w_locked_d = 1'b1;
                  end else begin
                     w_match_d  = '0;
                     w_locked_d = 1'b0;
                  end
               end else begin
                  if (w_fall) w_high_cap_d = r_cnt;
                  if (r_cnt == MaxCnt) begin
                     w_timeout_d = 1'b1;
                     w_locked_d  = 1'b0;
                     w_match_d   = '0;
                     w_state_d   = StArm;
                  end else begin
                     w_cnt_d = r_cnt + OneCnt;
                  end
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   assign period_out = r_period;
   assign high_out   = r_high;
   assign meas_valid = r_valid;
   assign locked     = r_locked;
   assign timeout    = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: scenario tasks with a timestamp-based reference model.
module tb_clk_period_meter;

   localparam int unsigned MaxP  = 16;
   localparam int unsigned LockN = 4;
   localparam int unsigned W     = $clog2(MaxP + 1);

   logic         clk_in = 1'b0;
   logic         reset  = 1'b1;
   logic         sig_in = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] period_out;
   logic [W-1:0] high_out;
   logic         meas_valid;
   logic         locked;
   logic         timeout;

   clk_period_meter #(
      .max_period(MaxP),
      .lock_count(LockN)
   ) u_dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .sig_in    (sig_in),
      .enable    (enable),
      .period_out(period_out),
      .high_out  (high_out),
      .meas_valid(meas_valid),
      .locked    (locked),
      .timeout   (timeout)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [W-1:0] per;
      logic [W-1:0] hi;
      logic         v;
      logic         lk;
      logic         to;
   } outs_t;

   typedef struct {
      int    c;
      outs_t obs;
      outs_t exp;
   } rec_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   rec_t log_q[$];

   // Reference model: sample history, timestamps of edges and a run length of equal periods.
   bit    m_hist[4];
   int    m_mode;  // 0 disabled, 1 waiting for first rise, 2 measuring
   int    m_t_rise;
   int    m_high_cap;
   int    m_run;
   bit    m_first;
   outs_t m_out;

   function automatic void model_reset();
      foreach (m_hist[i]) m_hist[i] = 1'b0;
      m_mode     = 0;
      m_t_rise   = 0;
      m_high_cap = 0;
      m_run      = 0;
      m_first    = 1'b0;
      m_out      = '0;
   endfunction

   // Effects registered at edge n come from the sample taken two edges earlier.
   function automatic void model_edge(input bit s, input bit en);
      bit rise, fall;
      int el;
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = s;
      rise = m_hist[2] && !m_hist[3];
      fall = !m_hist[2] && m_hist[3];
      m_out.v = 1'b0;
      if (!en) begin
         m_mode   = 0;
         m_out.lk = 1'b0;
         m_out.to = 1'b0;
         m_run    = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (rise) begin
            m_mode   = 2;
            m_t_rise = cyc;
            m_first  = 1'b1;
         end
      end else begin
         el = cyc - m_t_rise;
         if (rise) begin
            if (m_first || el != int'(m_out.per)) m_run = 1;
            else m_run++;
            m_out.per = W'(el);
            m_out.hi  = W'(m_high_cap);
            m_out.v   = 1'b1;
            m_out.to  = 1'b0;
            m_out.lk  = (m_run >= int'(LockN));
            m_first   = 1'b0;
            m_t_rise  = cyc;
         end else begin
            if (fall) m_high_cap = el;
            if (el == int'(MaxP)) begin
               m_out.to = 1'b1;
               m_out.lk = 1'b0;
               m_run    = 0;
               m_mode   = 1;
            end
         end
      end
   endfunction

   task automatic step(input bit s, input bit en);
      outs_t o;
      rec_t  r;
      @(negedge clk_in);
      sig_in = s;
      enable = en;
      @(posedge clk_in);
      cyc++;
      if (reset) model_edge(s, en);
      #1;
      o     = {period_out, high_out, meas_valid, locked, timeout};
      r.c   = cyc;
      r.obs = o;
      r.exp = m_out;
      log_q.push_back(r);
   endtask

   task automatic drive(input int hi, input int lo, input int n);
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
         for (int i = 0; i < lo; i++) step(1'b0, 1'b1);
      end
   endtask

   task automatic test_reset();
      outs_t o;
      int    nv, first_v;
      model_reset();
      #1 reset = 1'b0;
      #1;
      o = {period_out, high_out, meas_valid, locked, timeout};
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL reset_init got=%h want=0", o);
      end
      @(negedge clk_in);
      reset = 1'b1;
      log_q.delete();
      drive(3, 5, 3);
      foreach (log_q[i]) begin
         checks++;
         if (log_q[i].obs !== log_q[i].exp) begin
            failures++;
            $display("FAIL reset_pre_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
      end
      // Abort mid-measurement with an asynchronous reset.
      #2 reset = 1'b0;
      #1;
      o = {period_out, high_out, meas_valid, locked, timeout};
      checks++;
      if (o !== '0) begin
         failures++;
         $display("FAIL reset_async got=%h want=0", o);
      end
      model_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      #2 reset = 1'b1;
      log_q.delete();
      drive(3, 5, 3);
      nv      = 0;
      first_v = -1;
      foreach (log_q[i]) begin
         if (log_q[i].obs.v) begin
            nv++;
            if (first_v < 0) first_v = i;
         end
         checks++;
         if (log_q[i].obs !== log_q[i].exp) begin
            failures++;
            $display("FAIL reset_post_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
      end
      checks++;
      if (nv != 2 || first_v != 10) begin
         failures++;
         $display("FAIL reset_first_rise got valids=%0d first_at=%0d want valids=2 first_at=10",
                  nv, first_v);
      end
   endtask

   task automatic test_steady();
      int nv;
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
      log_q.delete();
      drive(3, 5, 8);
      nv = 0;
      foreach (log_q[i]) begin
         checks++;
         if (log_q[i].obs !== log_q[i].exp) begin
            failures++;
            $display("FAIL steady_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
         if (log_q[i].obs.v) begin
            nv++;
            checks++;
            if (log_q[i].obs.per !== W'(8) || log_q[i].obs.hi !== W'(3) ||
                log_q[i].obs.lk !== (nv >= 4) || i != 8 * nv + 2) begin
               failures++;
               $display("FAIL steady_meas n=%0d at=%0d got per=%0d hi=%0d lk=%b want per=8 hi=3 lk=%b at=%0d",
                        nv, i, log_q[i].obs.per, log_q[i].obs.hi, log_q[i].obs.lk, nv >= 4,
                        8 * nv + 2);
            end
         end
      end
      checks++;
      if (nv != 7) begin
         failures++;
         $display("FAIL steady_count got=%0d want=7", nv);
      end
   endtask

   task automatic test_period_change();
      int  n6;
      bit  seen;
      log_q.delete();
      drive(2, 4, 8);
      n6   = 0;
      seen = 1'b0;
      foreach (log_q[i]) begin
         checks++;
         if (log_q[i].obs !== log_q[i].exp) begin
            failures++;
            $display("FAIL change_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
         if (log_q[i].obs.v && log_q[i].obs.per == W'(6)) begin
            n6++;
            checks++;
            if (log_q[i].obs.hi !== W'(2) || log_q[i].obs.lk !== (n6 >= 4)) begin
               failures++;
               $display("FAIL change_p6 n=%0d got hi=%0d lk=%b want hi=2 lk=%b", n6,
                        log_q[i].obs.hi, log_q[i].obs.lk, n6 >= 4);
            end
         end
         if (log_q[i].obs.v && !seen && log_q[i].obs.per != W'(8)) begin
            seen = 1'b1;
            checks++;
            if (log_q[i].obs.per !== W'(6) || log_q[i].obs.lk !== 1'b0) begin
               failures++;
               $display("FAIL change_unlock got per=%0d lk=%b want per=6 lk=0",
                        log_q[i].obs.per, log_q[i].obs.lk);
            end
         end
      end
      checks++;
      if (n6 != 7) begin
         failures++;
         $display("FAIL change_count got=%0d want=7", n6);
      end
   endtask

   task automatic test_timeout();
      int first_to, rs;
      log_q.delete();
      // Last rise of the 2/4 pattern was registered 4 cycles before this hold starts.
      for (int i = 0; i < 24; i++) step(1'b0, 1'b1);
      first_to = -1;
      foreach (log_q[i]) if (first_to < 0 && log_q[i].obs.to) first_to = i;
      checks++;
      if (first_to != 12 || log_q[11].obs.lk !== 1'b1 ||
          (first_to >= 0 && log_q[first_to].obs.lk !== 1'b0)) begin
         failures++;
         $display("FAIL timeout_fire got at=%0d lk_before=%b want at=12 lk_before=1 lk_after=0",
                  first_to, log_q[11].obs.lk);
      end
      rs = log_q.size();
      drive(3, 5, 3);
      for (int i = rs; i < rs + 10; i++) begin
         checks++;
         if (log_q[i].obs.v !== 1'b0 || log_q[i].obs.to !== 1'b1) begin
            failures++;
            $display("FAIL timeout_arm idx=%0d got v=%b to=%b want v=0 to=1", i - rs,
                     log_q[i].obs.v, log_q[i].obs.to);
         end
      end
      checks++;
      if (log_q[rs+10].obs.v !== 1'b1 || log_q[rs+10].obs.to !== 1'b0 ||
          log_q[rs+10].obs.per !== W'(8)) begin
         failures++;
         $display("FAIL timeout_clear got v=%b to=%b per=%0d want v=1 to=0 per=8",
                  log_q[rs+10].obs.v, log_q[rs+10].obs.to, log_q[rs+10].obs.per);
      end
      foreach (log_q[i]) begin
         checks++;
         if (log_q[i].obs !== log_q[i].exp) begin
            failures++;
            $display("FAIL timeout_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
      end
   endtask

   task automatic test_boundary();
      int n16;
      bit any_to;
      log_q.delete();
      drive(8, 8, 4);
      n16    = 0;
      any_to = 1'b0;
      foreach (log_q[i]) begin
         checks++;
         if (log_q[i].obs !== log_q[i].exp) begin
            failures++;
            $display("FAIL boundary_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
         if (log_q[i].obs.to) any_to = 1'b1;
         if (log_q[i].obs.v && log_q[i].obs.per == W'(16)) begin
            n16++;
            checks++;
            if (log_q[i].obs.hi !== W'(8)) begin
               failures++;
               $display("FAIL boundary_high got=%0d want=8", log_q[i].obs.hi);
            end
         end
      end
      checks++;
      if (n16 != 3 || any_to) begin
         failures++;
         $display("FAIL boundary_max got n16=%0d to_seen=%b want n16=3 to_seen=0", n16, any_to);
      end
   endtask

   task automatic test_enable_drop();
      int d0;
      log_q.delete();
      drive(3, 5, 6);
      d0 = log_q.size();
      for (int j = 0; j < 8; j++) step(j < 3, j != 4);
      drive(3, 5, 3);
      foreach (log_q[i]) begin
         checks++;
         if (log_q[i].obs !== log_q[i].exp) begin
            failures++;
            $display("FAIL drop_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
      end
      checks++;
      if (log_q[d0+3].obs.lk !== 1'b1 || log_q[d0+4].obs.lk !== 1'b0 ||
          log_q[d0+4].obs.to !== 1'b0 || log_q[d0+4].obs.per !== W'(8)) begin
         failures++;
         $display("FAIL drop_clear got lk_before=%b lk=%b to=%b per=%0d want 1 0 0 8",
                  log_q[d0+3].obs.lk, log_q[d0+4].obs.lk, log_q[d0+4].obs.to,
                  log_q[d0+4].obs.per);
      end
      for (int i = d0 + 3; i < d0 + 18; i++) begin
         checks++;
         if (log_q[i].obs.v !== 1'b0) begin
            failures++;
            $display("FAIL drop_novalid idx=%0d got v=1 want v=0", i - d0);
         end
      end
      checks++;
      if (log_q[d0+18].obs.v !== 1'b1 || log_q[d0+18].obs.per !== W'(8)) begin
         failures++;
         $display("FAIL drop_resume got v=%b per=%0d want v=1 per=8", log_q[d0+18].obs.v,
                  log_q[d0+18].obs.per);
      end
   endtask

   task automatic test_random();
      int hi, lo, reps;
      log_q.delete();
      for (int k = 0; k < 120; k++) begin
         hi   = $urandom_range(1, 9);
         lo   = $urandom_range(1, 9);
         reps = $urandom_range(1, 6);
         if ($urandom_range(0, 7) == 0) lo = $urandom_range(10, 22);
         for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
            for (int i = 0; i < lo; i++) step(1'b0, $urandom_range(0, 39) != 0);
         end
      end
      foreach (log_q[i]) begin
         checks++;
         if (log_q[i].obs !== log_q[i].exp || log_q[i].obs.per > W'(MaxP)) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%h want=%h", log_q[i].c,
                     log_q[i].obs, log_q[i].exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_period_change();
      test_timeout();
      test_boundary();
      test_enable_drop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
